memoria_cache_wb: RTL

Parametrised, handshaked successor to the fixed 5-bit/8-bit cache-plus-main-memory pair. It holds a direct-mapped, write-back, write-allocate L1 with one word per line, and runs a request FSM that writes back dirty victims and fills misses over a req/ack port to main memory. It sits between the processor-side datapath and the main memory instance. It reports per-request whether data came from the cache or from main memory.

---
 rtl/memoria_pkg.sv | 34 +++
 rtl/memoria_cache_array.sv | 61 ++++++
 rtl/memoria_cache_wb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memoria_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memoria_pkg
// Purpose  : Shared types and default sizes for the write-back L1 cache
//            (memoria_cache_wb) and its line storage (cache_array).
// Revision : 1.0 - initial parametrised, handshaked release
// ============================================================================
package memoria_pkg;

    // Default sizes of the original fixed 5-bit address / 8-bit data pair
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_IDX_W  = 2;
    localparam int DEF_STAT_W = 16;

    // Request FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TAG       = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    // Cache line layout at the default sizes; modules built with other
    // parameters declare the same field order with their own widths.
    typedef struct packed {
        logic                             valid;
        logic                             dirty;
        logic [DEF_ADDR_W-DEF_IDX_W-1:0]  tag;
        logic [DEF_DATA_W-1:0]            data;
    } line_t;

endpackage
`default_nettype wire

// File: rtl/memoria_cache_array.sv
`default_nettype none
// ============================================================================
// Module   : cache_array
// Purpose  : Direct-mapped line storage (valid, dirty, tag, data) with a
//            combinational read by index, one synchronous write port and a
//            synchronous clear of every line on reset.
// Revision : 1.0 - initial release
// ============================================================================
module cache_array
    import memoria_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int TAG_W  = DEF_ADDR_W - DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_valid,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int c_lines = 1 << IDX_W;

    logic [c_lines-1:0] r_valid;
    logic [c_lines-1:0] r_dirty;
    logic [TAG_W-1:0]   r_tag  [c_lines];
    logic [DATA_W-1:0]  r_data [c_lines];

    assign rd_valid = r_valid[rd_idx];
    assign rd_dirty = r_dirty[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

    // Line storage: reset drops every line (dirty contents are discarded)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < c_lines; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (wr_en) begin
            r_valid[wr_idx] <= wr_valid;
            r_dirty[wr_idx] <= wr_dirty;
            r_tag[wr_idx]   <= wr_tag;
            r_data[wr_idx]  <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memoria_cache_wb.sv
`default_nettype none
// ============================================================================
// Module   : memoria_cache_wb
// Purpose  : Direct-mapped, write-back, write-allocate L1 (one word per line)
//            with a request FSM that writes back dirty victims and fills
//            misses over a req/ack main-memory port.
// Options  : CACHE_STATS_EN - adds saturating hit/miss counters and ports.
// Revision : 1.0 - initial release
// ============================================================================
module memoria_cache_wb
    import memoria_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              req_in,
    input  logic              wren_in,
    input  logic [ADDR_W-1:0] endereco_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] q_out,
    output logic              hit_cache_out,
    output logic              hit_memPrin_out,
    output logic              mem_req_out,
    output logic              mem_wren_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ack_in,
    input  logic [DATA_W-1:0] mem_q_in
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count_out,
    output logic [STAT_W-1:0] miss_count_out
`endif
);

    localparam int c_tag_w = ADDR_W - IDX_W;

    // Reject unusable parameter sets at elaboration
    if (IDX_W < 1 || IDX_W >= ADDR_W || STAT_W < 1 || DATA_W < 1) begin : g_param_check
        $error("memoria_cache_wb: illegal ADDR_W/IDX_W/DATA_W/STAT_W combination");
    end

    // Latched request and FSM state
    state_t              r_state, w_state_nxt;
    logic                r_wren,  w_wren_nxt;
    logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic [DATA_W-1:0]   r_data,  w_data_nxt;

    // Registered outputs
    logic                r_ready,     w_ready_nxt;
    logic                r_valid,     w_valid_nxt;
    logic [DATA_W-1:0]   r_q,         w_q_nxt;
    logic                r_hit_cache, w_hit_cache_nxt;
    logic                r_hit_mem,   w_hit_mem_nxt;
    logic                r_mem_req,   w_mem_req_nxt;
    logic                r_mem_wren,  w_mem_wren_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_data,  w_mem_data_nxt;

    // Line storage interface
    logic                w_rd_valid, w_rd_dirty;
    logic [c_tag_w-1:0]  w_rd_tag;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_wr_en, w_wr_valid, w_wr_dirty;
    logic [c_tag_w-1:0]  w_wr_tag;
    logic [DATA_W-1:0]   w_wr_data;

    logic [IDX_W-1:0]    w_idx;
    logic [c_tag_w-1:0]  w_tag;
    logic                w_hit;
    logic                w_ack;

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:IDX_W];
    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);
    // An acknowledge only counts while a memory request is outstanding
    assign w_ack = mem_ack_in && r_mem_req;

    cache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (c_tag_w),
        .DATA_W (DATA_W)
    ) u_cache_array (
        .clk      (clock_in),
        .rst      (reset_in),
        .rd_idx   (w_idx),
        .rd_valid (w_rd_valid),
        .rd_dirty (w_rd_dirty),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .wr_en    (w_wr_en),
        .wr_idx   (w_idx),
        .wr_valid (w_wr_valid),
        .wr_dirty (w_wr_dirty),
        .wr_tag   (w_wr_tag),
        .wr_data  (w_wr_data)
    );

    // Next-state, next-output and line-update logic of the request FSM
    always_comb begin
        w_state_nxt     = r_state;
        w_wren_nxt      = r_wren;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_q_nxt         = r_q;
        w_hit_cache_nxt = r_hit_cache;
        w_hit_mem_nxt   = r_hit_mem;
        w_mem_req_nxt   = r_mem_req;
        w_mem_wren_nxt  = r_mem_wren;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        // Default line write installs the latched request as a dirty line
        w_wr_en         = 1'b0;
        w_wr_valid      = 1'b1;
        w_wr_dirty      = 1'b1;
        w_wr_tag        = w_tag;
        w_wr_data       = r_data;

        case (r_state)
            IDLE: begin
                if (req_in) begin
                    w_wren_nxt  = wren_in;
                    w_addr_nxt  = endereco_in;
                    w_data_nxt  = data_in;
                    w_state_nxt = TAG;
                end
            end

            TAG: begin
                if (w_hit) begin
                    w_state_nxt     = IDLE;
                    w_valid_nxt     = 1'b1;
                    w_hit_cache_nxt = 1'b1;
                    w_hit_mem_nxt   = 1'b0;
                    if (r_wren) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_q_nxt = w_rd_data;
                    end
                end else if (w_rd_valid && w_rd_dirty) begin
                    w_state_nxt    = WRITEBACK;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_wren_nxt = 1'b1;
                    w_mem_addr_nxt = {w_rd_tag, w_idx};
                    w_mem_data_nxt = w_rd_data;
                end else if (!r_wren) begin
                    w_state_nxt    = FILL;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_wren_nxt = 1'b0;
                    w_mem_addr_nxt = r_addr;
                end else begin
                    // Write-allocate into a clean/empty line needs no memory
                    w_wr_en         = 1'b1;
                    w_state_nxt     = IDLE;
                    w_valid_nxt     = 1'b1;
                    w_hit_cache_nxt = 1'b0;
                    w_hit_mem_nxt   = 1'b0;
                end
            end

            WRITEBACK: begin
                if (w_ack) begin
                    if (!r_wren) begin
                        // Request stays up, retargeted as the fill read
                        w_state_nxt    = FILL;
                        w_mem_wren_nxt = 1'b0;
                        w_mem_addr_nxt = r_addr;
                    end else begin
                        w_wr_en         = 1'b1;
                        w_mem_req_nxt   = 1'b0;
                        w_mem_wren_nxt  = 1'b0;
                        w_state_nxt     = IDLE;
                        w_valid_nxt     = 1'b1;
                        w_hit_cache_nxt = 1'b0;
                        w_hit_mem_nxt   = 1'b0;
                    end
                end
            end

            FILL: begin
                if (w_ack) begin
                    w_wr_en         = 1'b1;
                    w_wr_dirty      = 1'b0;
                    w_wr_data       = mem_q_in;
                    w_q_nxt         = mem_q_in;
                    w_mem_req_nxt   = 1'b0;
                    w_state_nxt     = IDLE;
                    w_valid_nxt     = 1'b1;
                    w_hit_cache_nxt = 1'b0;
                    w_hit_mem_nxt   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt == IDLE);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state     <= IDLE;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_q         <= '0;
            r_hit_cache <= 1'b0;
            r_hit_mem   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wren      <= w_wren_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_ready     <= w_ready_nxt;
            r_valid     <= w_valid_nxt;
            r_q         <= w_q_nxt;
            r_hit_cache <= w_hit_cache_nxt;
            r_hit_mem   <= w_hit_mem_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_wren  <= w_mem_wren_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
        end
    end

    assign ready_out       = r_ready;
    assign valid_out       = r_valid;
    assign q_out           = r_q;
    assign hit_cache_out   = r_hit_cache;
    assign hit_memPrin_out = r_hit_mem;
    assign mem_req_out     = r_mem_req;
    assign mem_wren_out    = r_mem_wren;
    assign mem_addr_out    = r_mem_addr;
    assign mem_data_out    = r_mem_data;

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] r_hit_cnt, r_miss_cnt;

    // One saturating counter step per response, chosen by its hit flag
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_valid_nxt) begin
            if (w_hit_cache_nxt) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + STAT_W'(1);
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + STAT_W'(1);
            end
        end
    end

    assign hit_count_out  = r_hit_cnt;
    assign miss_count_out = r_miss_cnt;
`endif

endmodule
`default_nettype wire
